// File: rtl/shared_arith_arbiter.sv
// Round-robin arbiter sharing one unsigned add/mul datapath among N requesters.
// Latency: req sampled at edge T -> res_valid at T+2 (add) or T+1+MUL_CYCLES (mul).
// Backpressure: result held in DONE until res_ready; no new grant until one IDLE cycle after accept.
module shared_arith_arbiter #(
    parameter int N          = 4,
    parameter int W          = 8,
    parameter int MUL_CYCLES = 3,
    localparam int IW        = $clog2(N),
    localparam int CW        = $clog2(MUL_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    op,
    input  logic [N*W-1:0]  opa,
    input  logic [N*W-1:0]  opb,
    output logic [N-1:0]    gnt,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [IW-1:0]   res_id,
    output logic [W-1:0]    res_data,
    output logic            res_ovf
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cur_op_q, cur_op_d;
    logic [W-1:0]    cur_a_q, cur_a_d;
    logic [W-1:0]    cur_b_q, cur_b_d;
    logic [IW-1:0]   cur_id_q, cur_id_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            res_valid_q, res_valid_d;
    logic [IW-1:0]   res_id_q, res_id_d;
    logic [W-1:0]    res_data_q, res_data_d;
    logic            res_ovf_q, res_ovf_d;

    logic            win_found;
    logic [IW-1:0]   win_id;
    logic [IW-1:0]   cand;
    int              idx;

    logic [W:0]      sum;
    logic [2*W-1:0]  prod;
    logic [CW-1:0]   lat;

    // Cyclic search for the first pending request at or after ptr.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = IW'(idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign sum  = {1'b0, cur_a_q} + {1'b0, cur_b_q};
    assign prod = {{W{1'b0}}, cur_a_q} * {{W{1'b0}}, cur_b_q};
    assign lat  = cur_op_q ? CW'(MUL_CYCLES) : CW'(1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        cur_op_d    = cur_op_q;
        cur_a_d     = cur_a_q;
        cur_b_d     = cur_b_q;
        cur_id_d    = cur_id_q;
        gnt_d       = '0;
        busy_d      = busy_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = EXEC;
                    gnt_d    = {{(N-1){1'b0}}, 1'b1} << win_id;
                    cur_op_d = op[win_id];
                    cur_a_d  = opa[int'(win_id)*W +: W];
                    cur_b_d  = opb[int'(win_id)*W +: W];
                    cur_id_d = win_id;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            EXEC: begin
                // cnt counts EXEC cycles already spent; result is loaded once L have elapsed.
                if (cnt_q == lat) begin
                    state_d     = DONE;
                    res_valid_d = 1'b1;
                    res_id_d    = cur_id_q;
                    res_data_d  = cur_op_q ? prod[W-1:0] : sum[W-1:0];
                    res_ovf_d   = cur_op_q ? (|prod[2*W-1:W]) : sum[W];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    ptr_d       = (res_id_q == IW'(N-1)) ? '0 : res_id_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            cur_op_q    <= 1'b0;
            cur_a_q     <= '0;
            cur_b_q     <= '0;
            cur_id_q    <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            cur_op_q    <= cur_op_d;
            cur_a_q     <= cur_a_d;
            cur_b_q     <= cur_b_d;
            cur_id_q    <= cur_id_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_shared_arith_arbiter.sv
// Bench for shared_arith_arbiter: transaction-level reference model plus directed scenarios.
module tb_shared_arith_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MC = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     op = '0;
    logic [N*W-1:0]   opa = '0;
    logic [N*W-1:0]   opb = '0;
    logic             res_ready = 1'b1;
    logic [N-1:0]     gnt;
    logic             busy;
    logic             res_valid;
    logic [1:0]       res_id;
    logic [W-1:0]     res_data;
    logic             res_ovf;

    int n_checks = 0;
    int n_err    = 0;
    int glog[$];

    shared_arith_arbiter #(.N(N), .W(W), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .opa(opa), .opb(opb),
        .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_data(res_data), .res_ovf(res_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // ---------------- reference model: one transaction at a time ----------------
    bit              m_active;
    int              m_left;
    int              m_ptr;
    int              m_id;
    bit              m_op;
    int              m_a, m_b;
    logic [N-1:0]    exp_gnt;
    logic            exp_busy, exp_valid, exp_ovf;
    int              exp_id;
    logic [W-1:0]    exp_data;

    function automatic int pick(input int ptr, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int true_result(input bit o, input int a, input int b);
        return o ? a * b : a + b;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active  <= 1'b0;
            m_left    <= 0;
            m_ptr     <= 0;
            m_id      <= 0;
            m_op      <= 1'b0;
            m_a       <= 0;
            m_b       <= 0;
            exp_gnt   <= '0;
            exp_busy  <= 1'b0;
            exp_valid <= 1'b0;
            exp_id    <= 0;
            exp_data  <= '0;
            exp_ovf   <= 1'b0;
        end else begin
            exp_gnt <= '0;
            if (!m_active) begin
                if (req != '0) begin
                    m_active <= 1'b1;
                    m_id     <= pick(m_ptr, req);
                    m_op     <= op[pick(m_ptr, req)];
                    m_a      <= int'(opa[pick(m_ptr, req)*W +: W]);
                    m_b      <= int'(opb[pick(m_ptr, req)*W +: W]);
                    m_left   <= 1 + (op[pick(m_ptr, req)] ? MC : 1);
                    exp_gnt  <= N'(1 << pick(m_ptr, req));
                    exp_busy <= 1'b1;
                end
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    exp_valid <= 1'b1;
                    exp_id    <= m_id;
                    exp_data  <= W'(true_result(m_op, m_a, m_b) % (1 << W));
                    exp_ovf   <= (true_result(m_op, m_a, m_b) >= (1 << W));
                end
            end else if (res_ready) begin
                exp_valid <= 1'b0;
                exp_busy  <= 1'b0;
                m_active  <= 1'b0;
                m_ptr     <= (m_id + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        check("gnt", int'(gnt), int'(exp_gnt));
        check("busy", int'(busy), int'(exp_busy));
        check("res_valid", int'(res_valid), int'(exp_valid));
        if (exp_valid) begin
            check("res_id", int'(res_id), exp_id);
            check("res_data", int'(res_data), int'(exp_data));
            check("res_ovf", int'(res_ovf), int'(exp_ovf));
        end
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) glog.push_back(i);
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic set_req(input int i, input bit o, input int a, input int b);
        op[i]          = o;
        opa[i*W +: W]  = a[W-1:0];
        opb[i*W +: W]  = b[W-1:0];
        req[i]         = 1'b1;
    endtask

    task automatic wait_gnt(input int i);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (gnt[i]) begin
                check("gnt_onehot", int'(gnt), 1 << i);
                return;
            end
        end
        fail_timeout("wait_gnt");
    endtask

    task automatic wait_valid();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (res_valid) return;
        end
        fail_timeout("wait_valid");
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy) return;
        end
        fail_timeout("wait_idle");
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_gnt"}, int'(gnt), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_valid"}, int'(res_valid), 0);
        check({name, "_id"}, int'(res_id), 0);
        check({name, "_data"}, int'(res_data), 0);
        check({name, "_ovf"}, int'(res_ovf), 0);
    endtask

    task automatic do_op(input int i, input bit o, input int a, input int b,
                         input int ed, input int eo, input int lat);
        set_req(i, o, a, b);
        @(negedge clk);
        check("op_gnt", int'(gnt), 1 << i);
        req[i]        = 1'b0;
        op[i]         = ~o;
        opa[i*W +: W] = ~opa[i*W +: W];
        opb[i*W +: W] = ~opb[i*W +: W];
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check("op_latency", int'(res_valid), int'(k == lat));
        end
        check("op_data", int'(res_data), ed);
        check("op_ovf", int'(res_ovf), eo);
        check("op_id", int'(res_id), i);
        @(negedge clk);
        check("op_accepted", int'(res_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ord[5] = '{0, 1, 2, 3, 0};
        logic [W-1:0] held;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // 1: add with carry-out, latency 2
        do_op(0, 1'b0, 200, 100, 8'h2C, 1, 2);

        // 2: multiplies, latency 1+MC
        do_op(1, 1'b1, 15, 17, 8'hFF, 0, 4);
        do_op(1, 1'b1, 16, 16, 8'h00, 1, 4);

        // 3: all requesters held after reset -> full rotation and wrap
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        glog.delete();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 100 + 40 * i, 60);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (glog.size() >= 5) break;
        end
        req = '0;
        check("rr_grant_count", (glog.size() >= 5) ? 1 : 0, 1);
        wait_idle();
        for (int k = 0; k < 5; k++) begin
            if (k < glog.size()) check("rr_order", glog[k], ord[k]);
        end

        // 4: backpressure in DONE while another requester waits
        res_ready = 1'b0;
        set_req(3, 1'b0, 250, 10);
        wait_gnt(3);
        req[3] = 1'b0;
        set_req(2, 1'b0, 7, 9);
        wait_valid();
        held = res_data;
        check("bp_data", int'(held), 8'h04);
        check("bp_ovf", int'(res_ovf), 1);
        check("bp_id", int'(res_id), 3);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid_hold", int'(res_valid), 1);
            check("bp_data_hold", int'(res_data), int'(held));
            check("bp_no_gnt", int'(gnt), 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_released", int'(res_valid), 0);
        check("bp_idle_gap", int'(gnt), 0);
        @(negedge clk);
        check("bp_next_gnt", int'(gnt), 4'b0100);
        req[2] = 1'b0;
        wait_valid();
        check("bp_next_data", int'(res_data), 16);
        wait_idle();

        // 5: reset during a multiply, pending req2 re-arbitrated from ptr 0
        set_req(3, 1'b1, 20, 20);
        wait_gnt(3);
        req[3] = 1'b0;
        set_req(2, 1'b0, 1, 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_regrant", int'(gnt), 4'b0100);
        req[2] = 1'b0;
        wait_valid();
        check("rst_res_id", int'(res_id), 2);
        check("rst_res_data", int'(res_data), 3);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
